// File: rtl/uart_cmd_pkg.sv
// Shared types, ASCII constants and byte classifiers for the UART command decoder.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DATA    = 3'd2,
        ST_TERM    = 3'd3,
        ST_DISCARD = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_UNKNOWN_CMD = 2'd0,
        ERR_BAD_HEX     = 2'd1,
        ERR_BAD_TERM    = 2'd2,
        ERR_TIMEOUT     = 2'd3
    } err_code_e;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_W_UC  = 8'h57;
    localparam logic [7:0] ASCII_W_LC  = 8'h77;

    function automatic logic is_hex(input logic [7:0] b);
        return ((b >= 8'h30) && (b <= 8'h39)) ||
               ((b >= 8'h41) && (b <= 8'h46)) ||
               ((b >= 8'h61) && (b <= 8'h66));
    endfunction

    function automatic logic is_term(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == ASCII_W_UC) || (b == ASCII_W_LC);
    endfunction

    // Only meaningful when is_hex(b) is true.
    function automatic logic [3:0] hex_nibble(input logic [7:0] b);
        logic [7:0] v;
        if (b <= 8'h39)      v = b - 8'h30;
        else if (b <= 8'h46) v = b - 8'h37;
        else                 v = b - 8'h57;
        return v[3:0];
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_counter.sv
// Free-running up-counter with synchronous clear; used for the inter-byte timeout.
module uart_cmd_decoder_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    always_ff @(posedge clk) begin
        if (i_clear)   o_count <= '0;
        else if (i_en) o_count <= o_count + WIDTH'(1);
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses "W<a><h..h><CR|LF>" byte streams into register-write strobes with
// error reporting and resynchronisation on the next line terminator.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic [7:0]            i_data,
    input  logic                  i_data_valid,
    output logic [3:0]            o_addr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_wr,
    output logic                  o_err,
    output logic [1:0]            o_err_code,
    output logic                  o_busy
);

    localparam int unsigned NDIG   = DATA_WIDTH / 4;
    localparam int unsigned DCNT_W = $clog2(NDIG + 1);
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e                r_state;
    logic [3:0]            r_addr_sh;
    logic [DATA_WIDTH-1:0] r_data_sh;
    logic [DCNT_W-1:0]     r_dcnt;

    state_e                w_state_nxt;
    logic [3:0]            w_addr_sh_nxt;
    logic [DATA_WIDTH-1:0] w_data_sh_nxt;
    logic [DCNT_W-1:0]     w_dcnt_nxt;
    logic                  w_wr_nxt;
    logic                  w_err_nxt;
    logic [1:0]            w_code_nxt;
    logic [CNT_W-1:0]      w_tcount;
    logic                  w_timeout;
    logic                  w_hex;
    logic                  w_term;
    logic [3:0]            w_nib;

    uart_cmd_decoder_counter #(.WIDTH(CNT_W)) u_timeout_cnt (
        .clk     (clk),
        .i_clear (i_reset | i_data_valid | (r_state == ST_IDLE)),
        .i_en    (r_state != ST_IDLE),
        .o_count (w_tcount)
    );

    // A byte arriving in the same cycle always takes priority over the timeout.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && !i_data_valid &&
                       (w_tcount == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_hex  = is_hex(i_data);
    assign w_term = is_term(i_data);
    assign w_nib  = hex_nibble(i_data);

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_addr_sh  <= '0;
            r_data_sh  <= '0;
            r_dcnt     <= '0;
            o_addr     <= '0;
            o_wdata    <= '0;
            o_wr       <= 1'b0;
            o_err      <= 1'b0;
            o_err_code <= '0;
            o_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr_sh  <= w_addr_sh_nxt;
            r_data_sh  <= w_data_sh_nxt;
            r_dcnt     <= w_dcnt_nxt;
            o_wr       <= w_wr_nxt;
            o_err      <= w_err_nxt;
            o_err_code <= w_code_nxt;
            o_busy     <= (w_state_nxt != ST_IDLE);
            if (w_wr_nxt) begin
                o_addr  <= r_addr_sh;
                o_wdata <= r_data_sh;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_sh_nxt = r_addr_sh;
        w_data_sh_nxt = r_data_sh;
        w_dcnt_nxt    = r_dcnt;
        w_wr_nxt      = 1'b0;
        w_err_nxt     = 1'b0;
        w_code_nxt    = o_err_code;
        case (r_state)
            ST_IDLE: begin
                if (i_data_valid) begin
                    if (is_cmd(i_data)) begin
                        w_state_nxt = ST_ADDR;
                    end else if (!w_term && (i_data != ASCII_SPACE)) begin
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = ERR_UNKNOWN_CMD;
                        w_state_nxt = ST_DISCARD;
                    end
                end
            end
            ST_ADDR: begin
                if (i_data_valid) begin
                    if (w_hex) begin
                        w_addr_sh_nxt = w_nib;
                        w_dcnt_nxt    = '0;
                        w_state_nxt   = ST_DATA;
                    end else if (w_term) begin
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = ERR_BAD_TERM;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = ERR_BAD_HEX;
                        w_state_nxt = ST_DISCARD;
                    end
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_code_nxt  = ERR_TIMEOUT;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (i_data_valid) begin
                    if (w_hex) begin
                        w_data_sh_nxt = (r_data_sh << 4) | DATA_WIDTH'(w_nib);
                        w_dcnt_nxt    = r_dcnt + DCNT_W'(1);
                        if (r_dcnt == DCNT_W'(NDIG - 1)) w_state_nxt = ST_TERM;
                    end else if (w_term) begin
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = ERR_BAD_TERM;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = ERR_BAD_HEX;
                        w_state_nxt = ST_DISCARD;
                    end
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_code_nxt  = ERR_TIMEOUT;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_TERM: begin
                if (i_data_valid) begin
                    if (w_term) begin
                        w_wr_nxt    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = ERR_BAD_TERM;
                        w_state_nxt = ST_DISCARD;
                    end
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_code_nxt  = ERR_TIMEOUT;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (i_data_valid) begin
                    if (w_term) w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
